// File: rtl/pcbfpga_cfg_pkg.sv
// rtl/pcbfpga_cfg_pkg.sv - shared types, constants and CRC-8 step for the config loader
package pcbfpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_DATA,
    ST_CRC,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY    = 8'h07;

  // One MSB-first bit of CRC-8 (poly 0x07).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/pcbfpga_cfg_crc8.sv
// rtl/pcbfpga_cfg_crc8.sv - serial CRC-8 register with clear and enable
module pcbfpga_cfg_crc8
  import pcbfpga_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_step(crc_q, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/pcbfpga_cfg_loader.sv
// rtl/pcbfpga_cfg_loader.sv - serial config receiver: sync hunt, frame deserialize, frame write
// Optional per-frame CRC-8 check is enabled by defining PCBFPGA_CFG_CRC_EN.
module pcbfpga_cfg_loader
  import pcbfpga_cfg_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int          FRAME_BITS = 32,
  parameter logic [7:0]  SYNC       = SYNC_DEFAULT
)
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CFG_DIN,
  input  logic                  CFG_VALID,
  output logic                  FRAME_WE,
  output logic [ADDR_W-1:0]     FRAME_ADDR,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam int CNT_MAX = (ADDR_W > FRAME_BITS) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                                 : ((FRAME_BITS > 8) ? FRAME_BITS : 8);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_BITS - 1);

  cfg_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              sync_q, sync_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [FRAME_BITS-1:0]   data_q, data_d;
  logic                    commit_q, commit_d;
  logic                    frame_we_q, frame_we_d;
  logic [ADDR_W-1:0]       frame_addr_q, frame_addr_d;
  logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;

`ifdef PCBFPGA_CFG_CRC_EN
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(7);
  logic [7:0] crc_val;

  pcbfpga_cfg_crc8 u_crc8 (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (state_q == ST_HUNT),
    .en    (CFG_VALID && (state_q == ST_ADDR || state_q == ST_DATA)),
    .din   (CFG_DIN),
    .crc   (crc_val)
  );
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_HUNT;
      cnt_q        <= '0;
      sync_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      commit_q     <= 1'b0;
      frame_we_q   <= 1'b0;
      frame_addr_q <= '0;
      frame_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      commit_q     <= commit_d;
      frame_we_q   <= frame_we_d;
      frame_addr_q <= frame_addr_d;
      frame_data_q <= frame_data_d;
    end
  end

  // The sync window doubles as the received-CRC shifter; it is zeroed whenever
  // hunting restarts so stale frame bits can never fake a sync match.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sync_d       = sync_q;
    addr_d       = addr_q;
    data_d       = data_q;
    commit_d     = 1'b0;
    frame_we_d   = commit_q;
    frame_addr_d = commit_q ? addr_q : frame_addr_q;
    frame_data_d = commit_q ? data_q : frame_data_q;
    if (CFG_VALID) begin
      case (state_q)
        ST_HUNT: begin
          sync_d = {sync_q[6:0], CFG_DIN};
          if (sync_d == SYNC) begin
            state_d = ST_ADDR;
            sync_d  = '0;
          end
        end
        ST_ADDR: begin
          addr_d = {addr_q[ADDR_W-2:0], CFG_DIN};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == ADDR_LAST) begin
            state_d = (&addr_d) ? ST_DONE : ST_DATA;
          end
        end
        ST_DATA: begin
          data_d = {data_q[FRAME_BITS-2:0], CFG_DIN};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == DATA_LAST) begin
`ifdef PCBFPGA_CFG_CRC_EN
            state_d = ST_CRC;
`else
            state_d  = ST_HUNT;
            commit_d = 1'b1;
`endif
          end
        end
`ifdef PCBFPGA_CFG_CRC_EN
        ST_CRC: begin
          sync_d = {sync_q[6:0], CFG_DIN};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CRC_LAST) begin
            if (sync_d == crc_val) begin
              state_d  = ST_HUNT;
              commit_d = 1'b1;
              sync_d   = '0;
            end else begin
              state_d = ST_ERR;
            end
          end
        end
`endif
        default: ;
      endcase
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    BUSY  = 1'b0;
    DONE  = 1'b0;
    ERROR = 1'b0;
    case (state_q)
      ST_ADDR, ST_DATA, ST_CRC: BUSY = 1'b1;
      ST_DONE:                  DONE = 1'b1;
`ifdef PCBFPGA_CFG_CRC_EN
      ST_ERR:                   ERROR = 1'b1;
`endif
      default: ;
    endcase
  end

  assign FRAME_WE   = frame_we_q;
  assign FRAME_ADDR = frame_addr_q;
  assign FRAME_DATA = frame_data_q;

endmodule

// File: tb/tb_pcbfpga_cfg_loader.sv
// tb/tb_pcbfpga_cfg_loader.sv - scoreboard bench for pcbfpga_cfg_loader
module tb_pcbfpga_cfg_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CFG_DIN;
  logic        CFG_VALID;
  logic        FRAME_WE;
  logic [7:0]  FRAME_ADDR;
  logic [31:0] FRAME_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int exp_wr  = 0;
  int busy_cycles = 0;
  logic prev_we = 1'b0;
  logic [39:0] sb[$];

  pcbfpga_cfg_loader dut (
    .CLK        (CLK),
    .RST        (RST),
    .CFG_DIN    (CFG_DIN),
    .CFG_VALID  (CFG_VALID),
    .FRAME_WE   (FRAME_WE),
    .FRAME_ADDR (FRAME_ADDR),
    .FRAME_DATA (FRAME_DATA),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-wise MSB-first CRC-8 (poly 0x07, init 0) over addr then data.
  function automatic logic [7:0] frame_crc(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] c;
    logic [39:0] msg;
    c = 8'h00;
    msg = {a, d};
    for (int b = 4; b >= 0; b--) begin
      c = c ^ msg[b*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always @(negedge CLK) begin
    logic [39:0] e;
    if (BUSY) busy_cycles++;
    if (FRAME_WE) begin
      wr_cnt++;
      check("we_single_cycle", prev_we, 1'b0);
      check("we_done_exclusive", DONE, 1'b0);
      check("sb_has_entry", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("frame_addr", FRAME_ADDR, e[39:32]);
        check("frame_data", FRAME_DATA, e[31:0]);
      end
    end
    prev_we = FRAME_WE;
  end

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        CFG_VALID = 1'b0;
        @(posedge CLK); #1;
      end
    end
    CFG_DIN   = b;
    CFG_VALID = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], gaps);
  endtask

  task automatic idle(input int n);
    CFG_VALID = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // flip corrupts sent data while the CRC still covers the original data.
  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit gaps,
                            input bit expect_wr, input logic [31:0] flip);
    send_bits(32'hA5, 8, gaps);
    send_bits({24'h0, a}, 8, gaps);
    send_bits(d ^ flip, 32, gaps);
`ifdef PCBFPGA_CFG_CRC_EN
    send_bits({24'h0, frame_crc(a, d)}, 8, gaps);
`endif
    if (expect_wr) begin
      sb.push_back({a, d});
      exp_wr++;
    end
  endtask

  task automatic do_reset();
    CFG_VALID = 1'b0;
    CFG_DIN   = 1'b0;
    RST       = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_error", ERROR, 1'b0);
    check("rst_we", FRAME_WE, 1'b0);
    check("rst_addr", FRAME_ADDR, 8'h00);
    check("rst_data", FRAME_DATA, 32'h0);

    busy_cycles = 0;
    send_frame(8'h03, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
    idle(3);
    check("busy_cycles", busy_cycles, 40);
    check("hold_addr", FRAME_ADDR, 8'h03);
    check("hold_data", FRAME_DATA, 32'hDEADBEEF);

    send_frame(8'h03, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0);
    send_frame(8'h04, 32'h00000001, 1'b0, 1'b1, 32'h0);
    idle(3);
    check("b2b_writes", wr_cnt, 3);

    send_bits(32'hFF, 8, 1'b0);
    send_bits(32'h5A, 8, 1'b0);
    send_bits(32'hA, 4, 1'b0);
    send_frame(8'h10, 32'h0BADF00D, 1'b0, 1'b1, 32'h0);
    idle(3);
    check("hunt_writes", wr_cnt, 4);

    send_bits(32'hA5, 8, 1'b0);
    send_bits(32'h22, 8, 1'b0);
    send_bits(32'h0ABC, 12, 1'b0);
    CFG_VALID = 1'b0;
    #3 RST = 1'b0;
    #1;
    check("arst_busy", BUSY, 1'b0);
    check("arst_we", FRAME_WE, 1'b0);
    check("arst_addr", FRAME_ADDR, 8'h00);
    check("arst_data", FRAME_DATA, 32'h0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    send_frame(8'h07, 32'h13579BDF, 1'b0, 1'b1, 32'h0);
    idle(3);
    check("arst_writes", wr_cnt, 5);

`ifdef PCBFPGA_CFG_CRC_EN
    send_frame(8'h55, 32'h12345678, 1'b0, 1'b1, 32'h0);
    idle(3);
    check("crc_ok_error", ERROR, 1'b0);
    send_frame(8'h56, 32'hCAFEF00D, 1'b0, 1'b0, 32'h00001000);
    idle(3);
    check("crc_bad_error", ERROR, 1'b1);
    check("crc_bad_busy", BUSY, 1'b0);
    send_frame(8'h57, 32'h0000FFFF, 1'b0, 1'b0, 32'h0);
    idle(3);
    check("err_sticky", ERROR, 1'b1);
    do_reset();
    check("err_cleared", ERROR, 1'b0);
`else
    check("error_tied_low", ERROR, 1'b0);
`endif

    send_bits(32'hA5, 8, 1'b0);
    send_bits(32'hFF, 8, 1'b0);
    idle(3);
    check("end_done", DONE, 1'b1);
    check("end_busy", BUSY, 1'b0);
    send_frame(8'h20, 32'h11112222, 1'b0, 1'b0, 32'h0);
    idle(3);
    check("done_sticky", DONE, 1'b1);

    idle(4);
    check("total_writes", wr_cnt, exp_wr);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
